// File: rtl/i2s_clkws_cfg_seq.sv
// ---------------------------------------------------------------------------
// i2s_clkws_cfg_seq
//
// Configuration sequencer that sits in front of i2s_clkws_gen. Register-file
// requests are captured on cfg_update_i and applied so that the clock mux
// selects, dividers, word fields and DSP fields never change while the
// downstream clock generators, gates or WS generators are enabled.
//
// A request whose static fields (sel, div_0, div_1, word, dsp) differ from the
// applied ones takes the full path: drain the enables, wait for the slowest
// divided clock to stop, load the static fields, let them settle, re-enable.
// A request that only touches the enables skips straight to re-enabling.
//
// Parameters:
//   GUARD_CYCLES  - extra clk_i cycles added to the quiesce wait
//   SETTLE_CYCLES - clk_i cycles held between loading static fields and
//                   re-enabling (8-bit max)
//
// Ports:
//   clk_i           system clock
//   rstn_i          synchronous active-low reset
//   cfg_update_i    single-cycle pulse, samples all req_* inputs
//   req_en_i        {pdm_en, slave_en, master_en}
//   req_sel_i       {sel_slave_ext, sel_slave_num, sel_master_ext, sel_master_num}
//   req_div_0_i     master divider
//   req_div_1_i     slave divider
//   req_word_i      {word_size_1, word_num_1, word_size_0, word_num_0}
//   req_dsp_i       {dsp_en, dsp_mode, dsp_setup_time[15:0]}
//   applied_*_o     fields currently driven to i2s_clkws_gen
//   busy_o          a sequence is in progress
//   done_o          one-cycle pulse when the new configuration is fully applied
// ---------------------------------------------------------------------------
module i2s_clkws_cfg_seq #(
   parameter int GUARD_CYCLES  = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        cfg_update_i,
   input  logic [2:0]  req_en_i,
   input  logic [3:0]  req_sel_i,
   input  logic [15:0] req_div_0_i,
   input  logic [15:0] req_div_1_i,
   input  logic [15:0] req_word_i,
   input  logic [17:0] req_dsp_i,
   output logic [2:0]  applied_en_o,
   output logic [3:0]  applied_sel_o,
   output logic [15:0] applied_div_0_o,
   output logic [15:0] applied_div_1_o,
   output logic [15:0] applied_word_o,
   output logic [17:0] applied_dsp_o,
   output logic        busy_o,
   output logic        done_o
);

   // The static set is the group of fields that may only change while every
   // downstream enable is off. Keeping it as one packed record makes the
   // "did anything static change" test a single compare.
   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] div_0;
      logic [15:0] div_1;
      logic [15:0] word;
      logic [17:0] dsp;
   } static_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      QUIESCE,
      APPLY,
      SETTLE,
      ENABLE
   } state_t;

   state_t      state;
   logic [17:0] cnt;

   logic [2:0]  shadow_en;
   static_t     shadow_st;
   logic [2:0]  pend_en;
   static_t     pend_st;
   logic        pending;

   logic [2:0]  applied_en;
   static_t     applied_st;

   static_t     req_st;
   logic [15:0] div_max;
   logic [17:0] div_max_p1;
   logic [17:0] quiesce_len;

   // Bundle the request fields into the same record layout as the applied
   // static set so shadow/pend/applied can be copied as a whole.
   assign req_st = {req_sel_i, req_div_0_i, req_div_1_i, req_word_i, req_dsp_i};

   // Quiesce wait length: two periods of the slowest divided clock that is
   // currently running (old applied dividers, not the requested ones), plus a
   // guard for the enable synchronisers and clock-gate latch. The largest
   // value, 2*65536+GUARD, needs 18 bits, so the sum is widened before adding.
   assign div_max     = (applied_st.div_0 > applied_st.div_1) ? applied_st.div_0
                                                              : applied_st.div_1;
   assign div_max_p1  = {2'b00, div_max} + 18'd1;
   assign quiesce_len = {div_max_p1[16:0], 1'b0} + 18'(GUARD_CYCLES);

   // Outputs come straight from registers; busy is a decode of the state.
   assign applied_en_o    = applied_en;
   assign applied_sel_o   = applied_st.sel;
   assign applied_div_0_o = applied_st.div_0;
   assign applied_div_1_o = applied_st.div_1;
   assign applied_word_o  = applied_st.word;
   assign applied_dsp_o   = applied_st.dsp;
   assign busy_o          = (state != IDLE);

   // Main sequencer. Applied enables are only cleared in CHECK and only
   // loaded in ENABLE; the applied static set is only loaded in APPLY, which
   // is always reached through CHECK's clear and the quiesce wait, so the
   // static fields can never move under a live enable.
   //
   // Requests arriving while a sequence is running go into a single pending
   // slot (last writer wins) and are picked up from ENABLE. A request landing
   // in the ENABLE cycle itself with nothing already pending ends up queued
   // while the FSM returns to IDLE, so IDLE drains the pending slot first.
   // The queue write sits after the case statement so that a new request in
   // the same cycle that a queued one is consumed stays queued.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         cnt        <= '0;
         shadow_en  <= '0;
         shadow_st  <= '0;
         pend_en    <= '0;
         pend_st    <= '0;
         pending    <= 1'b0;
         applied_en <= '0;
         applied_st <= '0;
         done_o     <= 1'b0;
      end else begin
         done_o <= 1'b0;

         case (state)
            IDLE: begin
               if (pending) begin
                  shadow_en <= pend_en;
                  shadow_st <= pend_st;
                  pending   <= 1'b0;
                  state     <= CHECK;
               end else if (cfg_update_i) begin
                  shadow_en <= req_en_i;
                  shadow_st <= req_st;
                  state     <= CHECK;
               end
            end

            CHECK: begin
               if (shadow_st == applied_st) begin
                  state <= ENABLE;
               end else begin
                  applied_en <= '0;
                  cnt        <= quiesce_len;
                  state      <= QUIESCE;
               end
            end

            QUIESCE: begin
               if (cnt == '0) begin
                  state <= APPLY;
               end else begin
                  cnt <= cnt - 18'd1;
               end
            end

            APPLY: begin
               applied_st <= shadow_st;
               cnt        <= 18'(SETTLE_CYCLES);
               state      <= SETTLE;
            end

            SETTLE: begin
               if (cnt == '0) begin
                  state <= ENABLE;
               end else begin
                  cnt <= cnt - 18'd1;
               end
            end

            ENABLE: begin
               applied_en <= shadow_en;
               done_o     <= 1'b1;
               if (pending) begin
                  shadow_en <= pend_en;
                  shadow_st <= pend_st;
                  pending   <= 1'b0;
                  state     <= CHECK;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase

         if (cfg_update_i && ((state != IDLE) || pending)) begin
            pend_en <= req_en_i;
            pend_st <= req_st;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_clkws_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_i2s_clkws_cfg_seq
//
// Self-checking bench for i2s_clkws_cfg_seq with GUARD_CYCLES=8 and
// SETTLE_CYCLES=4. A table of requests with hand-derived latencies walks the
// main slow/fast paths (including a 17-bit quiesce length), two hand-written
// sequences cover request queueing and reset during SETTLE, and a random
// traffic phase is compared every cycle against a timestamp-based model of
// the sequencing rules.
// ---------------------------------------------------------------------------
module tb_i2s_clkws_cfg_seq;

   localparam int GUARD  = 8;
   localparam int SETTLE = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        cfg_update_i = 1'b0;
   logic [2:0]  req_en_i = '0;
   logic [3:0]  req_sel_i = '0;
   logic [15:0] req_div_0_i = '0;
   logic [15:0] req_div_1_i = '0;
   logic [15:0] req_word_i = '0;
   logic [17:0] req_dsp_i = '0;
   logic [2:0]  applied_en_o;
   logic [3:0]  applied_sel_o;
   logic [15:0] applied_div_0_o;
   logic [15:0] applied_div_1_o;
   logic [15:0] applied_word_o;
   logic [17:0] applied_dsp_o;
   logic        busy_o;
   logic        done_o;

   int tests_run = 0;
   int tests_failed = 0;

   i2s_clkws_cfg_seq #(
      .GUARD_CYCLES (GUARD),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .cfg_update_i   (cfg_update_i),
      .req_en_i       (req_en_i),
      .req_sel_i      (req_sel_i),
      .req_div_0_i    (req_div_0_i),
      .req_div_1_i    (req_div_1_i),
      .req_word_i     (req_word_i),
      .req_dsp_i      (req_dsp_i),
      .applied_en_o   (applied_en_o),
      .applied_sel_o  (applied_sel_o),
      .applied_div_0_o(applied_div_0_o),
      .applied_div_1_o(applied_div_1_o),
      .applied_word_o (applied_word_o),
      .applied_dsp_o  (applied_dsp_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   // Free-running system clock, 10 time units per cycle.
   always #5 clk_i = ~clk_i;

   // Static set packed as {sel, div_0, div_1, word, dsp}, 70 bits.
   typedef struct {
      logic [2:0]  en;
      logic [69:0] st;
      logic [2:0]  exp_en_c2;
      int          exp_static_cyc;
      int          exp_done_cyc;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [69:0] mkSt(input logic [3:0] sel, input logic [15:0] d0,
                                        input logic [15:0] d1, input logic [15:0] word,
                                        input logic [17:0] dsp);
      return {sel, d0, d1, word, dsp};
   endfunction

   function automatic logic [69:0] curStatic();
      return {applied_sel_o, applied_div_0_o, applied_div_1_o, applied_word_o, applied_dsp_o};
   endfunction

   // Compare one observed value with its expected value and log failures.
   task automatic checkOutput(input string name, input logic [69:0] actual,
                              input logic [69:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive a request for the current cycle; the caller clears cfg_update_i.
   task automatic applyStimulus(input logic [2:0] en, input logic [69:0] st);
      req_en_i     = en;
      req_sel_i    = st[69:66];
      req_div_0_i  = st[65:50];
      req_div_1_i  = st[49:34];
      req_word_i   = st[33:18];
      req_dsp_i    = st[17:0];
      cfg_update_i = 1'b1;
   endtask

   // -----------------------------------------------------------------------
   // Reference model: each running sequence is described by the cycle its
   // check happens, and the absolute cycles at which the enables drop, the
   // static set lands, and the new enables plus done appear, all worked out
   // from the quiesce/settle lengths when the sequence starts.
   // -----------------------------------------------------------------------
   logic [2:0]  m_en;
   logic [69:0] m_static;
   logic        m_done, m_busy;
   bit          m_active, m_slow, m_pending;
   int          m_c, m_apply_cyc, m_enable_cyc;
   logic [2:0]  m_sh_en, m_pend_en;
   logic [69:0] m_sh_st, m_pend_st;

   task automatic modelReset();
      m_en = '0; m_static = '0; m_done = 1'b0; m_busy = 1'b0;
      m_active = 0; m_slow = 0; m_pending = 0;
      m_c = -1; m_apply_cyc = -1; m_enable_cyc = -1;
      m_sh_en = '0; m_sh_st = '0; m_pend_en = '0; m_pend_st = '0;
   endtask

   task automatic startSeq(input int c, input logic [2:0] en, input logic [69:0] st);
      int d0, d1, w;
      d0 = int'(m_static[65:50]);
      d1 = int'(m_static[49:34]);
      w  = 2 * (((d0 > d1) ? d0 : d1) + 1) + GUARD;
      m_sh_en  = en;
      m_sh_st  = st;
      m_active = 1;
      m_c      = c;
      m_slow   = (st != m_static);
      if (m_slow) begin
         m_apply_cyc  = c + w + 2;
         m_enable_cyc = c + w + 4 + SETTLE;
      end else begin
         m_apply_cyc  = -1;
         m_enable_cyc = c + 1;
      end
   endtask

   // Advance the model across the edge at the end of cycle n.
   task automatic modelStep(input int n, input bit rst, input bit upd,
                            input logic [2:0] en, input logic [69:0] st);
      if (rst) begin
         modelReset();
         return;
      end
      m_done = 1'b0;
      if (m_active) begin
         if (m_slow && n == m_c) m_en = '0;
         if (m_slow && n == m_apply_cyc) m_static = m_sh_st;
         if (n == m_enable_cyc) begin
            m_en   = m_sh_en;
            m_done = 1'b1;
            if (m_pending) begin
               m_pending = 0;
               startSeq(n + 1, m_pend_en, m_pend_st);
            end else begin
               m_active = 0;
            end
         end
         if (upd) begin
            m_pend_en = en; m_pend_st = st; m_pending = 1;
         end
      end else begin
         if (m_pending) begin
            startSeq(n + 1, m_pend_en, m_pend_st);
            m_pending = upd;
            if (upd) begin
               m_pend_en = en; m_pend_st = st;
            end
         end else if (upd) begin
            startSeq(n + 1, en, st);
         end
      end
      m_busy = m_active;
   endtask

   // -----------------------------------------------------------------------
   // Test sequence
   // -----------------------------------------------------------------------
   logic [69:0] prev_st, base_st, rst_st;
   logic [2:0]  en_c2, rnd_en;
   int          done_cyc, stat_cyc, ndone, d1c, d2c;
   bit          busy_ok, saw7, saw_done, saw_busy, prev_done, rnd_upd, rnd_rst;

   initial begin
      // Latencies follow W = 2*(max(old div_0, old div_1)+1) + 8 and
      // done at cycle W+10 (slow) or 3 (fast); static lands at W+4.
      vecs[0] = '{3'b011, mkSt(4'h0, 16'd4, 16'd2, 16'h0000, 18'h0),       3'b000, 14,    20};
      vecs[1] = '{3'b011, mkSt(4'h5, 16'd4, 16'd2, 16'h0000, 18'h0),       3'b000, 22,    28};
      vecs[2] = '{3'b001, mkSt(4'h5, 16'd4, 16'd2, 16'h0000, 18'h0),       3'b011, -1,    3};
      vecs[3] = '{3'b000, mkSt(4'h5, 16'd4, 16'd2, 16'hA5C3, 18'h0),       3'b000, 22,    28};
      vecs[4] = '{3'b000, mkSt(4'h5, 16'd4, 16'd2, 16'hA5C3, 18'h0),       3'b000, -1,    3};
      vecs[5] = '{3'b111, mkSt(4'h5, 16'd100, 16'd2, 16'hA5C3, 18'h0),     3'b000, 22,    28};
      vecs[6] = '{3'b110, mkSt(4'h5, 16'h7FFF, 16'd2, 16'hA5C3, 18'h21234), 3'b000, 214,  220};
      vecs[7] = '{3'b101, mkSt(4'h5, 16'd5, 16'd3, 16'hA5C3, 18'h30001),   3'b000, 65548, 65554};
      vecs[8] = '{3'b010, mkSt(4'hA, 16'd5, 16'd3, 16'hA5C3, 18'h30001),   3'b000, 24,    30};

      // Reset with random request traffic present.
      rstn_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         rst_st = {$urandom, $urandom, $urandom};
         applyStimulus(3'($urandom), rst_st);
      end
      @(negedge clk_i);
      checkOutput("reset_en", applied_en_o, 3'b000);
      checkOutput("reset_static", curStatic(), 70'd0);
      checkOutput("reset_busy", busy_o, 1'b0);
      checkOutput("reset_done", done_o, 1'b0);
      cfg_update_i = 1'b0;
      rstn_i = 1'b1;

      // Table-driven request vectors.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         prev_st = curStatic();
         applyStimulus(vecs[i].en, vecs[i].st);
         done_cyc = -1; stat_cyc = -1; en_c2 = 'x; busy_ok = 1;
         for (int c = 1; c <= 70000; c++) begin
            @(negedge clk_i);
            cfg_update_i = 1'b0;
            if (c == 2) en_c2 = applied_en_o;
            if (stat_cyc < 0 && curStatic() != prev_st) stat_cyc = c;
            if (done_o) begin
               done_cyc = c;
               break;
            end
            if (!busy_o) busy_ok = 0;
         end
         checkOutput($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].exp_done_cyc);
         checkOutput($sformatf("vec%0d_static_cycle", i), stat_cyc, vecs[i].exp_static_cyc);
         checkOutput($sformatf("vec%0d_en_cycle2", i), en_c2, vecs[i].exp_en_c2);
         checkOutput($sformatf("vec%0d_busy_window", i), busy_ok, 1'b1);
         checkOutput($sformatf("vec%0d_final_en", i), applied_en_o, vecs[i].en);
         checkOutput($sformatf("vec%0d_final_static", i), curStatic(), vecs[i].st);
         checkOutput($sformatf("vec%0d_busy_at_done", i), busy_o, 1'b0);
         @(negedge clk_i);
         checkOutput($sformatf("vec%0d_done_single", i), done_o, 1'b0);
      end

      // Two updates queued during QUIESCE: last writer wins, two done pulses.
      @(negedge clk_i);
      applyStimulus(3'b011, mkSt(4'h3, 16'd5, 16'd3, 16'hA5C3, 18'h30001));
      ndone = 0; d1c = -1; d2c = -1; saw7 = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk_i);
         cfg_update_i = 1'b0;
         if (applied_div_0_o == 16'd7) saw7 = 1;
         if (done_o) begin
            ndone++;
            if (ndone == 1) begin
               d1c = c;
               checkOutput("queue_first_div0", applied_div_0_o, 16'd5);
               checkOutput("queue_first_sel", applied_sel_o, 4'h3);
            end else if (ndone == 2) begin
               d2c = c;
            end
         end
         if (c == 5) applyStimulus(3'b011, mkSt(4'h3, 16'd7, 16'd3, 16'hA5C3, 18'h30001));
         if (c == 8) applyStimulus(3'b011, mkSt(4'h3, 16'd9, 16'd3, 16'hA5C3, 18'h30001));
      end
      checkOutput("queue_done_count", ndone, 2);
      checkOutput("queue_first_done_cycle", d1c, 30);
      checkOutput("queue_second_done_cycle", d2c, 59);
      checkOutput("queue_div7_seen", saw7, 1'b0);
      checkOutput("queue_final_div0", applied_div_0_o, 16'd9);
      checkOutput("queue_final_en", applied_en_o, 3'b011);

      // Reset pulse during SETTLE with a request pending.
      @(negedge clk_i);
      applyStimulus(3'b111, mkSt(4'h3, 16'd2, 16'd3, 16'hA5C3, 18'h30001));
      saw_done = 0; saw_busy = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk_i);
         cfg_update_i = 1'b0;
         if (c == 10) applyStimulus(3'b001, mkSt(4'h3, 16'd1, 16'd3, 16'hA5C3, 18'h30001));
         if (c == 33) begin
            checkOutput("rstseq_static_applied", applied_div_0_o, 16'd2);
            checkOutput("rstseq_busy_in_settle", busy_o, 1'b1);
            rstn_i = 1'b0;
         end
         if (c == 34) begin
            checkOutput("rstseq_outputs_zero", {applied_en_o, curStatic()}, 73'd0);
            checkOutput("rstseq_busy_zero", busy_o, 1'b0);
            checkOutput("rstseq_done_zero", done_o, 1'b0);
            rstn_i = 1'b1;
         end
         if (c > 34 && done_o) saw_done = 1;
         if (c > 34 && busy_o) saw_busy = 1;
      end
      checkOutput("rstseq_no_done_after", saw_done, 1'b0);
      checkOutput("rstseq_no_busy_after", saw_busy, 1'b0);
      checkOutput("rstseq_still_zero", {applied_en_o, curStatic()}, 73'd0);

      // Random traffic against the model, plus the safety invariants.
      modelReset();
      base_st = '0;
      prev_st = curStatic();
      prev_done = 0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk_i);
         checkOutput($sformatf("rnd%0d_en", n), applied_en_o, m_en);
         checkOutput($sformatf("rnd%0d_static", n), curStatic(), m_static);
         checkOutput($sformatf("rnd%0d_busy", n), busy_o, m_busy);
         checkOutput($sformatf("rnd%0d_done", n), done_o, m_done);
         if (curStatic() != prev_st)
            checkOutput($sformatf("rnd%0d_en_on_static_change", n), applied_en_o, 3'b000);
         checkOutput($sformatf("rnd%0d_done_double", n), done_o & prev_done, 1'b0);
         prev_st = curStatic();
         prev_done = done_o;

         rnd_upd = ($urandom_range(0, 5) == 0);
         rnd_rst = ($urandom_range(0, 399) == 0);
         rnd_en  = 3'($urandom);
         if ($urandom_range(0, 2) == 0)
            base_st = mkSt(4'($urandom), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 6)),
                           16'($urandom), 18'($urandom));
         if (rnd_upd) applyStimulus(rnd_en, base_st);
         else cfg_update_i = 1'b0;
         rstn_i = !rnd_rst;
         modelStep(n, rnd_rst, rnd_upd, rnd_en, base_st);
      end
      @(negedge clk_i);
      cfg_update_i = 1'b0;
      rstn_i = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
